// File: rtl/mem_bridge.sv
// Memory/IO bus bridge: turns one exec-stage access request into one or two
// Wishbone cycles on a 16-bit bus, stalling exec with block until it completes.
module mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc,
  input  logic [19:0] addr,
  input  logic [15:0] wr_data,
  input  logic        we,
  input  logic        m_io,
  input  logic        byteop,
  output logic [15:0] memout,
  output logic        block,
  output logic        bus_err,
  output logic [18:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_tga_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, CYC1, CYC2} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [19:0] a_q;
  logic        byte_q;
  logic [7:0]  lo_q;
  logic [15:0] tcnt;
  logic [15:0] memout_q;
  logic        split_q, last, fire, final_ack;
  logic [15:0] rd_val;

  // IO space only decodes 16 address bits, so the upper word-address bits stay zero
  function automatic logic [18:0] word_adr(input logic [19:0] a, input logic io);
    return io ? {4'b0, a[15:1]} : a[19:1];
  endfunction

  function automatic logic [19:0] next_byte(input logic [19:0] a, input logic io);
    return io ? {4'b0, a[15:0] + 16'd1} : a + 20'd1;
  endfunction

  assign split_q   = ~byte_q & a_q[0];
  assign last      = (state == CYC2) || (state == CYC1 && !split_q);
  assign fire      = (TIMEOUT != 0) && (state != IDLE) && !wb_ack_i && (tcnt == TO_LAST);
  assign final_ack = (state != IDLE) && ((wb_ack_i && last) || fire);
  assign block     = acc & ~final_ack;
  assign wb_stb_o  = wb_cyc_o;

  always_comb begin
    rd_val = wb_dat_i;
    if (fire)                rd_val = 16'hFFFF;
    else if (state == CYC2)  rd_val = {wb_dat_i[7:0], lo_q};
    else if (byte_q)         rd_val = {8'h00, a_q[0] ? wb_dat_i[15:8] : wb_dat_i[7:0]};
  end

  assign memout = (final_ack && !wb_we_o) ? rd_val : memout_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = CYC1;
      CYC1:    if (final_ack) state_nxt = IDLE;
               else if (wb_ack_i) state_nxt = CYC2;
      CYC2:    if (final_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      byte_q   <= 1'b0;
      lo_q     <= '0;
      tcnt     <= '0;
      memout_q <= '0;
      bus_err  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_tga_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      bus_err <= fire;
      if (final_ack && !wb_we_o) memout_q <= rd_val;
      case (state)
        IDLE: if (acc) begin
          a_q      <= addr;
          byte_q   <= byteop;
          tcnt     <= '0;
          wb_cyc_o <= 1'b1;
          wb_we_o  <= we;
          wb_tga_o <= m_io;
          wb_adr_o <= word_adr(addr, m_io);
          if (byteop) begin
            wb_sel_o <= addr[0] ? 2'b10 : 2'b01;
            wb_dat_o <= {wr_data[7:0], wr_data[7:0]};
          end else if (addr[0]) begin
            // swapped so each half lands on the lane its byte address selects
            wb_sel_o <= 2'b10;
            wb_dat_o <= {wr_data[7:0], wr_data[15:8]};
          end else begin
            wb_sel_o <= 2'b11;
            wb_dat_o <= wr_data;
          end
        end
        CYC1, CYC2: begin
          if (final_ack) begin
            wb_cyc_o <= 1'b0;
          end else if (wb_ack_i) begin
            lo_q     <= wb_dat_i[15:8];
            wb_adr_o <= word_adr(next_byte(a_q, wb_tga_o), wb_tga_o);
            wb_sel_o <= 2'b01;
            tcnt     <= '0;
          end else begin
            tcnt     <= tcnt + 16'd1;
          end
        end
        default: wb_cyc_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: drives the bus slave by hand and checks bus
// fields, stall length and returned data against hand-computed values.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc;
  logic [19:0] addr;
  logic [15:0] wr_data;
  logic        we, m_io, byteop;
  logic [15:0] memout;
  logic        block, bus_err;
  logic [18:0] wb_adr_o;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  int n_chk = 0;
  int n_pass = 0;

  logic [18:0] c_adr[2];
  logic [1:0]  c_sel[2];
  logic [15:0] c_dat[2];
  logic        c_tga[2];
  logic        c_we[2];
  logic [15:0] m_fin;
  int          nblk;

  mem_bridge #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .acc(acc), .addr(addr), .wr_data(wr_data), .we(we),
    .m_io(m_io), .byteop(byteop), .memout(memout), .block(block), .bus_err(bus_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one access; the slave acks phase 0 after w1 wait cycles with r1 and
  // phase 1 after w2 wait cycles with r2. Bus fields are captured at each ack.
  task automatic access(input string tag, input logic [19:0] a, input logic [15:0] d,
                        input logic w, input logic io, input logic bo,
                        input int w1, input logic [15:0] r1,
                        input int w2, input logic [15:0] r2);
    int ph, wc;
    logic done;
    acc = 1'b1; addr = a; wr_data = d; we = w; m_io = io; byteop = bo;
    ph = 0; wc = 0; nblk = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      wb_ack_i = 1'b0;
      if (wb_cyc_o && ph < 2) begin
        if (wc == ((ph == 0) ? w1 : w2)) begin
          wb_ack_i = 1'b1;
          wb_dat_i = (ph == 0) ? r1 : r2;
          c_adr[ph] = wb_adr_o; c_sel[ph] = wb_sel_o; c_dat[ph] = wb_dat_o;
          c_tga[ph] = wb_tga_o; c_we[ph] = wb_we_o;
          ph++; wc = 0;
        end else wc++;
      end
      @(negedge clk);
      if (block) nblk++;
      else begin done = 1'b1; m_fin = memout; end
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    acc = 1'b0; wb_ack_i = 1'b0;
  endtask

  initial begin
    int  ncyc;
    logic done;
    rst = 1'b1; acc = 1'b0; addr = '0; wr_data = '0; we = 1'b0; m_io = 1'b0;
    byteop = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_adr", 32'(wb_adr_o), 0);
    chk("rst_memout", 32'(memout), 0);
    chk("rst_err", 32'(bus_err), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_block", 32'(block), 0);

    // 1: aligned word read, one wait state
    access("t1", 20'h01234, 16'h0, 1'b0, 1'b0, 1'b0, 1, 16'hBEEF, 0, 16'h0);
    chk("t1_adr", 32'(c_adr[0]), 32'h091A);
    chk("t1_sel", 32'(c_sel[0]), 32'h3);
    chk("t1_stb", 32'(wb_stb_o), 32'(wb_cyc_o));
    chk("t1_memout", 32'(m_fin), 32'hBEEF);
    chk("t1_block", 32'(nblk), 2);
    @(negedge clk);
    chk("t1_hold", 32'(memout), 32'hBEEF);
    chk("t1_cyc_off", 32'(wb_cyc_o), 0);
    @(posedge clk); #1;

    // 2: unaligned word write splits in two
    access("t2", 20'h00011, 16'hA55A, 1'b1, 1'b0, 1'b0, 0, 16'h0, 0, 16'h0);
    chk("t2_adr0", 32'(c_adr[0]), 32'h0008);
    chk("t2_sel0", 32'(c_sel[0]), 32'h2);
    chk("t2_dat0", 32'(c_dat[0]), 32'h5AA5);
    chk("t2_we", 32'(c_we[0]), 1);
    chk("t2_adr1", 32'(c_adr[1]), 32'h0009);
    chk("t2_sel1", 32'(c_sel[1]), 32'h1);
    chk("t2_dat1", 32'(c_dat[1]), 32'h5AA5);
    chk("t2_block", 32'(nblk), 2);
    chk("t2_memout", 32'(m_fin), 32'hBEEF);

    // 3: unaligned read at the top of memory wraps to word 0
    access("t3", 20'hFFFFF, 16'h0, 1'b0, 1'b0, 1'b0, 0, 16'h1200, 0, 16'h0034);
    chk("t3_adr0", 32'(c_adr[0]), 32'h7FFFF);
    chk("t3_adr1", 32'(c_adr[1]), 32'h00000);
    chk("t3_memout", 32'(m_fin), 32'h3412);

    // 4: IO byte read from the odd lane, then IO word wrap at 0xFFFF
    access("t4", 20'h003DB, 16'h0, 1'b0, 1'b1, 1'b1, 0, 16'h7F00, 0, 16'h0);
    chk("t4_tga", 32'(c_tga[0]), 1);
    chk("t4_sel", 32'(c_sel[0]), 32'h2);
    chk("t4_adr", 32'(c_adr[0]), 32'h01ED);
    chk("t4_memout", 32'(m_fin), 32'h007F);
    access("t4w", 20'hAFFFF, 16'h0, 1'b0, 1'b1, 1'b0, 0, 16'hAB00, 0, 16'h00CD);
    chk("t4w_adr0", 32'(c_adr[0]), 32'h7FFF);
    chk("t4w_adr1", 32'(c_adr[1]), 32'h0000);
    chk("t4w_memout", 32'(m_fin), 32'hCDAB);

    // even byte write duplicates the byte on both lanes
    access("tb", 20'h00100, 16'h1234, 1'b1, 1'b0, 1'b1, 0, 16'h0, 0, 16'h0);
    chk("tb_sel", 32'(c_sel[0]), 32'h1);
    chk("tb_dat", 32'(c_dat[0]), 32'h3434);
    chk("tb_memout", 32'(m_fin), 32'hCDAB);

    // 5: no ack ever -> timeout after 255 strobed cycles
    acc = 1'b1; addr = 20'h00400; we = 1'b0; m_io = 1'b0; byteop = 1'b0; wb_ack_i = 1'b0;
    ncyc = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (wb_cyc_o) ncyc++;
      if (!block) begin done = 1'b1; m_fin = memout; end
      @(posedge clk); #1;
    end
    chk("t5_done", 32'(done), 1);
    chk("t5_cycles", 32'(ncyc), 255);
    chk("t5_memout", 32'(m_fin), 32'hFFFF);
    chk("t5_err", 32'(bus_err), 1);
    chk("t5_cyc", 32'(wb_cyc_o), 0);
    acc = 1'b0;
    @(posedge clk); #1;
    chk("t5_err_pulse", 32'(bus_err), 0);
    chk("t5_hold", 32'(memout), 32'hFFFF);

    // 6: async reset during CYC1 drops the cycle immediately
    acc = 1'b1; addr = 20'h00040; we = 1'b0; m_io = 1'b0; byteop = 1'b0;
    @(posedge clk); #1;
    chk("t6_cyc_up", 32'(wb_cyc_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_cyc", 32'(wb_cyc_o), 0);
    chk("t6_stb", 32'(wb_stb_o), 0);
    chk("t6_memout", 32'(memout), 0);
    acc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_idle", 32'(wb_cyc_o), 0);
    access("t6b", 20'h00002, 16'h0, 1'b0, 1'b0, 1'b0, 0, 16'h1111, 0, 16'h0);
    chk("t6b_adr", 32'(c_adr[0]), 32'h0001);
    chk("t6b_block", 32'(nblk), 1);
    chk("t6b_memout", 32'(m_fin), 32'h1111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
